// File: rtl/mapa_arbiter_if.sv
// Bus bundle between the map arbiter, its clients (VGA reader, two snake engines) and the map RAM.
// slave = arbiter side, master = client/RAM side.
interface mapa_arbiter_if;
  logic        vga_req;
  logic [9:0]  vga_x, vga_y;
  logic [3:0]  vga_data;
  logic        vga_valid;
  logic [1:0]  snk_req, snk_we;
  logic [19:0] snk_x, snk_y;
  logic [7:0]  snk_wdata;
  logic [1:0]  snk_gnt;
  logic [3:0]  snk_rdata;
  logic [1:0]  snk_rvalid;
  logic [9:0]  ram_x, ram_y;
  logic        ram_we;
  logic [3:0]  ram_wdata;
  logic [3:0]  ram_rdata;

  modport slave (
    input  vga_req, vga_x, vga_y, snk_req, snk_we, snk_x, snk_y, snk_wdata, ram_rdata,
    output vga_data, vga_valid, snk_gnt, snk_rdata, snk_rvalid, ram_x, ram_y, ram_we, ram_wdata
  );
  modport master (
    output vga_req, vga_x, vga_y, snk_req, snk_we, snk_x, snk_y, snk_wdata, ram_rdata,
    input  vga_data, vga_valid, snk_gnt, snk_rdata, snk_rvalid, ram_x, ram_y, ram_we, ram_wdata
  );
endinterface

// File: rtl/mapa_arbiter.sv
// Single-port game-map RAM arbiter: VGA reads first, snakes round-robin, 2-cycle read latency.
// Define MAPA_ARB_STARVE_EN to let a snake waiting STARVE_MAX cycles preempt one VGA slot.
module mapa_arbiter #(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int STARVE_MAX  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mapa_arbiter_if.slave bus
);
  typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_S0, OWN_S1} own_e;
  typedef struct packed { own_e own; logic oor; } tag_t;

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

  logic [1:0][9:0] sx, sy;
  logic [1:0][3:0] swd;
  logic [1:0]      elig, win_snk;
  logic            win_vga, sel, rr_q;
  logic [9:0]      nx_x, nx_y;
  logic            nx_oor, nx_rd;
  tag_t            tag_q;

  assign sx  = bus.snk_x;
  assign sy  = bus.snk_y;
  assign swd = bus.snk_wdata;

  // A snake whose grant is high this cycle is masked so a late req drop is never re-granted.
  assign elig = bus.snk_req & ~bus.snk_gnt;

  function automatic logic [1:0] pick(input logic [1:0] m, input logic pref1);
    pick = (m == 2'b11) ? (pref1 ? 2'b10 : 2'b01) : m;
  endfunction

`ifdef MAPA_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [1:0][CW-1:0] wait_q;
  logic [1:0]         hit;

  always_comb begin
    hit = 2'b00;
    for (int i = 0; i < 2; i++) hit[i] = elig[i] && (wait_q[i] >= CW'(STARVE_MAX));
  end

  always_comb begin
    win_vga = 1'b0;
    win_snk = 2'b00;
    if (|hit)             win_snk = pick(hit, rr_q);
    else if (bus.vga_req) win_vga = 1'b1;
    else                  win_snk = pick(elig, rr_q);
  end

  // Saturating wait counters; a snake stuck at the limit keeps its claim until served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (win_snk[i])                                  wait_q[i] <= '0;
        else if (elig[i] && wait_q[i] != CW'(STARVE_MAX)) wait_q[i] <= wait_q[i] + 1'b1;
      end
    end
  end
`else
  always_comb begin
    win_vga = 1'b0;
    win_snk = 2'b00;
    if (bus.vga_req) win_vga = 1'b1;
    else             win_snk = pick(elig, rr_q);
  end
`endif

  assign sel    = win_snk[1];
  assign nx_x   = win_vga ? bus.vga_x : sx[sel];
  assign nx_y   = win_vga ? bus.vga_y : sy[sel];
  assign nx_oor = (nx_x >= 10'(MAPA_WIDTH)) || (nx_y >= 10'(MAPA_HEIGHT));
  assign nx_rd  = (|win_snk) && !bus.snk_we[sel];

  // Issue stage: drive RAM, tag in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ram_x     <= '0;
      bus.ram_y     <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_wdata <= '0;
      bus.snk_gnt   <= 2'b00;
      rr_q          <= 1'b0;
      tag_q         <= '{own: OWN_NONE, oor: 1'b0};
    end else begin
      bus.snk_gnt <= win_snk;
      bus.ram_we  <= (|win_snk) && bus.snk_we[sel] && !nx_oor;
      if (win_vga || (|win_snk)) begin
        bus.ram_x <= nx_x;
        bus.ram_y <= nx_y;
      end
      if ((|win_snk) && bus.snk_we[sel]) bus.ram_wdata <= swd[sel];
      if (|win_snk) rr_q <= ~sel;
      tag_q.oor <= nx_oor;
      if (win_vga)    tag_q.own <= OWN_VGA;
      else if (nx_rd) tag_q.own <= sel ? OWN_S1 : OWN_S0;
      else            tag_q.own <= OWN_NONE;
    end
  end

  // Return stage: out-of-range reads report an empty cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.vga_data   <= '0;
      bus.vga_valid  <= 1'b0;
      bus.snk_rdata  <= '0;
      bus.snk_rvalid <= 2'b00;
    end else begin
      bus.vga_valid  <= (tag_q.own == OWN_VGA);
      bus.snk_rvalid <= {tag_q.own == OWN_S1, tag_q.own == OWN_S0};
      if (tag_q.own == OWN_VGA)
        bus.vga_data <= tag_q.oor ? 4'b0000 : bus.ram_rdata;
      if (tag_q.own == OWN_S0 || tag_q.own == OWN_S1)
        bus.snk_rdata <= tag_q.oor ? 4'b0000 : bus.ram_rdata;
    end
  end
endmodule

// File: tb/tb_mapa_arbiter.sv
// Directed bench for mapa_arbiter with a behavioural 40x30 map RAM (cell (x,y) preloaded to x+2y+1).
module tb_mapa_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;

`ifdef MAPA_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  mapa_arbiter_if bus ();
  mapa_arbiter #(.MAPA_WIDTH(40), .MAPA_HEIGHT(30), .STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [3:0] mem [30][40];
  logic loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int y = 0; y < 30; y++)
        for (int x = 0; x < 40; x++) mem[y][x] <= 4'(x + 2 * y + 1);
      loaded <= 1'b1;
    end else if (bus.ram_we) begin
      mem[bus.ram_y[4:0]][bus.ram_x[5:0]] <= bus.ram_wdata;
    end
  end
  // Out-of-range addresses return junk so the forced-zero path is visible.
  assign bus.ram_rdata = (bus.ram_x < 10'd40 && bus.ram_y < 10'd30) ? mem[bus.ram_y[4:0]][bus.ram_x[5:0]] : 4'hF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.vga_req = 1'b0; bus.vga_x = '0; bus.vga_y = '0;
    bus.snk_req = 2'b00; bus.snk_we = 2'b00;
    bus.snk_x = '0; bus.snk_y = '0; bus.snk_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++; if (bus.ram_x !== 10'd0 || bus.ram_y !== 10'd0) $display("FAIL reset_addr got=%0d,%0d exp=0,0", bus.ram_x, bus.ram_y); else passed++;
    total++; if (bus.ram_we !== 1'b0 || bus.ram_wdata !== 4'd0) $display("FAIL reset_ramw got we=%b wd=%h exp 0/0", bus.ram_we, bus.ram_wdata); else passed++;
    total++; if (bus.vga_valid !== 1'b0 || bus.vga_data !== 4'd0) $display("FAIL reset_vga got v=%b d=%h exp 0/0", bus.vga_valid, bus.vga_data); else passed++;
    total++; if (bus.snk_gnt !== 2'b00 || bus.snk_rvalid !== 2'b00 || bus.snk_rdata !== 4'd0)
      $display("FAIL reset_snk got g=%b rv=%b d=%h exp 00/00/0", bus.snk_gnt, bus.snk_rvalid, bus.snk_rdata); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] eg, erv;
    logic [3:0] ed;
    bus.snk_req = 2'b11; bus.snk_we = 2'b00;
    bus.snk_x = {10'd2, 10'd1}; bus.snk_y = {10'd2, 10'd1};
    for (int i = 1; i <= 4; i++) begin
      tick();
      eg  = (i % 2 == 1) ? 2'b01 : 2'b10;
      erv = (i == 1) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
      ed  = (i % 2 == 0) ? 4'd4 : 4'd7;
      total++; if (bus.snk_gnt !== eg) $display("FAIL rr_gnt%0d got=%b exp=%b", i, bus.snk_gnt, eg); else passed++;
      total++; if (bus.snk_rvalid !== erv) $display("FAIL rr_rvalid%0d got=%b exp=%b", i, bus.snk_rvalid, erv); else passed++;
      if (i > 1) begin
        total++; if (bus.snk_rdata !== ed) $display("FAIL rr_rdata%0d got=%h exp=%h", i, bus.snk_rdata, ed); else passed++;
      end
    end
    bus.snk_req = 2'b00;
    tick(); tick();
    total++; if (bus.snk_gnt !== 2'b00 || bus.ram_we !== 1'b0) $display("FAIL idle_pulse got g=%b we=%b exp 00/0", bus.snk_gnt, bus.ram_we); else passed++;
    total++; if (bus.ram_x !== 10'd2 || bus.ram_y !== 10'd2) $display("FAIL idle_hold got=%0d,%0d exp=2,2", bus.ram_x, bus.ram_y); else passed++;
    // Serve snake 0 alone, then a simultaneous request must go to snake 1.
    bus.snk_req = 2'b01; tick();
    bus.snk_req = 2'b00; tick();
    bus.snk_req = 2'b11; tick();
    total++; if (bus.snk_gnt !== 2'b10) $display("FAIL rr_pointer got=%b exp=10", bus.snk_gnt); else passed++;
    bus.snk_req = 2'b01; tick();
    total++; if (bus.snk_gnt !== 2'b01) $display("FAIL rr_second got=%b exp=01", bus.snk_gnt); else passed++;
    bus.snk_req = 2'b00; tick(); tick();
  endtask

  task automatic test_snake_wr_rd();
    bus.snk_req = 2'b01; bus.snk_we = 2'b01;
    bus.snk_x = {10'd0, 10'd10}; bus.snk_y = {10'd0, 10'd5}; bus.snk_wdata = {4'h0, 4'h2};
    tick();
    total++; if (bus.snk_gnt !== 2'b01 || bus.ram_we !== 1'b1) $display("FAIL wr_issue got g=%b we=%b exp 01/1", bus.snk_gnt, bus.ram_we); else passed++;
    total++; if (bus.ram_x !== 10'd10 || bus.ram_y !== 10'd5 || bus.ram_wdata !== 4'h2)
      $display("FAIL wr_bus got=%0d,%0d,%h exp=10,5,2", bus.ram_x, bus.ram_y, bus.ram_wdata); else passed++;
    bus.snk_we = 2'b00;
    tick();
    total++; if (bus.snk_gnt !== 2'b00 || bus.ram_we !== 1'b0) $display("FAIL wr_mask got g=%b we=%b exp 00/0", bus.snk_gnt, bus.ram_we); else passed++;
    tick();
    total++; if (bus.snk_gnt !== 2'b01 || bus.ram_we !== 1'b0) $display("FAIL rd_issue got g=%b we=%b exp 01/0", bus.snk_gnt, bus.ram_we); else passed++;
    bus.snk_req = 2'b00;
    tick();
    total++; if (bus.snk_rvalid !== 2'b01 || bus.snk_rdata !== 4'h2) $display("FAIL rd_back got rv=%b d=%h exp 01/2", bus.snk_rvalid, bus.snk_rdata); else passed++;
    tick();
    total++; if (bus.snk_rvalid !== 2'b00 || bus.snk_rdata !== 4'h2) $display("FAIL rd_hold got rv=%b d=%h exp 00/2", bus.snk_rvalid, bus.snk_rdata); else passed++;
  endtask

  task automatic test_vga_stream();
    bus.vga_req = 1'b1; bus.vga_y = 10'd0; bus.vga_x = 10'd0;
    tick();
    total++; if (bus.vga_valid !== 1'b0 || bus.ram_x !== 10'd0 || bus.ram_we !== 1'b0)
      $display("FAIL vga_issue got v=%b x=%0d we=%b exp 0/0/0", bus.vga_valid, bus.ram_x, bus.ram_we); else passed++;
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) bus.vga_x = 10'(i); else bus.vga_req = 1'b0;
      tick();
      total++; if (bus.vga_valid !== 1'b1 || bus.vga_data !== 4'(i))
        $display("FAIL vga_beat%0d got v=%b d=%h exp 1/%h", i, bus.vga_valid, bus.vga_data, 4'(i)); else passed++;
    end
    tick();
    total++; if (bus.vga_valid !== 1'b0 || bus.vga_data !== 4'd4) $display("FAIL vga_hold got v=%b d=%h exp 0/4", bus.vga_valid, bus.vga_data); else passed++;
  endtask

  task automatic test_out_of_range();
    bus.snk_req = 2'b10; bus.snk_we = 2'b10;
    bus.snk_x = {10'd40, 10'd0}; bus.snk_y = {10'd0, 10'd0}; bus.snk_wdata = {4'h3, 4'h0};
    tick();
    total++; if (bus.snk_gnt !== 2'b10 || bus.ram_we !== 1'b0) $display("FAIL oor_wr got g=%b we=%b exp 10/0", bus.snk_gnt, bus.ram_we); else passed++;
    bus.snk_we = 2'b00; bus.snk_x = {10'd0, 10'd0}; bus.snk_y = {10'd30, 10'd0};
    tick(); tick();
    total++; if (bus.snk_gnt !== 2'b10 || bus.ram_we !== 1'b0) $display("FAIL oor_rd got g=%b we=%b exp 10/0", bus.snk_gnt, bus.ram_we); else passed++;
    bus.snk_req = 2'b00;
    tick();
    total++; if (bus.snk_rvalid !== 2'b10 || bus.snk_rdata !== 4'h0) $display("FAIL oor_data got rv=%b d=%h exp 10/0", bus.snk_rvalid, bus.snk_rdata); else passed++;
    tick();
  endtask

  task automatic test_starvation();
    logic [1:0] eg, erv;
    logic       ev;
    bus.vga_req = 1'b1; bus.vga_x = 10'd5; bus.vga_y = 10'd0;
    bus.snk_req = 2'b01; bus.snk_we = 2'b00; bus.snk_x = {10'd0, 10'd3}; bus.snk_y = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      eg  = (STARVE && i == 9)  ? 2'b01 : 2'b00;
      erv = (STARVE && i == 10) ? 2'b01 : 2'b00;
      ev  = (i >= 2) && !(STARVE && i == 10);
      total++; if (bus.snk_gnt !== eg) $display("FAIL starve_gnt%0d got=%b exp=%b", i, bus.snk_gnt, eg); else passed++;
      total++; if (bus.snk_rvalid !== erv) $display("FAIL starve_rv%0d got=%b exp=%b", i, bus.snk_rvalid, erv); else passed++;
      total++; if (bus.vga_valid !== ev) $display("FAIL starve_vga%0d got=%b exp=%b", i, bus.vga_valid, ev); else passed++;
      if (i >= 2) begin
        total++; if (bus.vga_data !== 4'd6) $display("FAIL starve_vdata%0d got=%h exp=6", i, bus.vga_data); else passed++;
      end
      if (erv == 2'b01) begin
        total++; if (bus.snk_rdata !== 4'd4) $display("FAIL starve_sdata got=%h exp=4", bus.snk_rdata); else passed++;
      end
      if (bus.snk_gnt[0]) bus.snk_req = 2'b00;
    end
    idle_inputs();
    tick(); tick(); tick();
  endtask

  task automatic test_reset_midstream();
    bus.vga_req = 1'b1; bus.vga_x = 10'd2; bus.vga_y = 10'd0;
    tick();
    rst_n = 1'b0;
    #1;
    total++; if (bus.ram_x !== 10'd0 || bus.snk_gnt !== 2'b00 || bus.ram_we !== 1'b0)
      $display("FAIL mid_rst_issue got x=%0d g=%b we=%b exp 0/00/0", bus.ram_x, bus.snk_gnt, bus.ram_we); else passed++;
    total++; if (bus.vga_data !== 4'd0 || bus.snk_rdata !== 4'd0 || bus.vga_valid !== 1'b0)
      $display("FAIL mid_rst_ret got vd=%h sd=%h v=%b exp 0/0/0", bus.vga_data, bus.snk_rdata, bus.vga_valid); else passed++;
    bus.vga_req = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (bus.vga_valid !== 1'b0 || bus.snk_rvalid !== 2'b00)
        $display("FAIL mid_rst_stray%0d got v=%b rv=%b exp 0/00", i, bus.vga_valid, bus.snk_rvalid); else passed++;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_round_robin();
    test_snake_wr_rd();
    test_vga_stream();
    test_out_of_range();
    test_starvation();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end
endmodule
